jtcontra_gfx_romslot: RTL
=========================

Name: jtcontra_gfx_romslot

Overview:
- Serves the gfx1/gfx2 ROM fetch requests that the video block issues.
- Each client presents `addr` and `cs` and waits for `ok` with `data`.
- The block arbitrates the two clients onto a single SDRAM request port, caches the last word fetched per client, and answers with `ok` and `data`.
- It sits between the video block and the SDRAM controller in the game top.

Parameters:
- GFX1_OFFSET, 22'h08_0000, SDRAM word base added to gfx1 addresses.
- GFX2_OFFSET, 22'h10_0000, SDRAM word base added to gfx2 addresses.

Ports:
- rst  in  1  asynchronous reset, active-high.
- clk  in  1  system clock (48 MHz).
- gfx1_addr  in  18  gfx1 word address.
- gfx1_cs  in  1  gfx1 fetch enable.
- gfx1_data  out  16  gfx1 returned word.
- gfx1_ok  out  1  gfx1_data valid for the current gfx1_addr.
- gfx2_addr  in  18  gfx2 word address.
- gfx2_cs  in  1  gfx2 fetch enable.
- gfx2_data  out  16  gfx2 returned word.
- gfx2_ok  out  1  gfx2_data valid for the current gfx2_addr.
- sdram_addr  out  22  SDRAM word address.
- sdram_req  out  1  request strobe, held until acknowledged.
- sdram_ack  in  1  one-cycle pulse: controller has accepted the request.
- sdram_rdy  in  1  one-cycle pulse: sdram_din holds the requested word.
- sdram_din  in  16  SDRAM read data.

Behaviour:
- Per-client cache: tag[17:0], data[15:0], valid.
  - hit_n = valid_n & (tag_n == gfxn_addr).
  - gfxn_ok = gfxn_cs & hit_n. This is combinational, so it drops in the same cycle that addr changes.
  - gfxn_data = cached data_n. It is never combinationally routed from sdram_din.
- miss_n = gfxn_cs & ~hit_n.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
- IDLE:
  - If any miss: choose the client, latch sel and req_tag (= gfxsel_addr), drive sdram_addr = OFFSET_sel + {4'd0, addr}, set sdram_req=1, go to WAIT_ACK.
  - When both miss, the client not served last wins (round-robin bit `last`). After reset `last`=1, so gfx1 wins first.
- WAIT_ACK: on sdram_ack, clear sdram_req and go to WAIT_DATA. sdram_addr is held stable throughout.
- WAIT_DATA:
  - On sdram_rdy, write data_sel = sdram_din, tag_sel = req_tag, valid_sel = 1. Set `last` = sel and go to IDLE.
  - ok can therefore rise at the earliest on the cycle after rdy.
- A new request may be issued on the cycle after the return to IDLE; there is no back-to-back issue in the rdy cycle.
- Address change mid-fetch: the fetched word is still stored under req_tag, which is the old address. hit fails for the new address, so a fresh fetch follows.
- cs dropped mid-fetch: the transaction completes normally and the cache is updated. Nothing is aborted.
- An sdram_ack or sdram_rdy pulse in an unexpected state is ignored.
- ack and rdy in the same cycle while in WAIT_ACK: take the ack, drop the rdy. The controller never does this.
- Address arithmetic is 22-bit modulo; overflow wraps.
- Reset, including mid-operation: state=IDLE, sdram_req=0, sdram_addr=0, valid_1=valid_2=0, tags=0, data=0, last=1. All ok outputs are therefore 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT_ACK=2'd1, WAIT_DATA=2'd2) and the default offsets.
- Natural sub-module: jtcontra_romslot_cache, instantiated twice. It holds tag, data and valid, computes hit/ok, and takes a write strobe from the FSM.
- Arbiter and FSM live in the top.

Test Plan:
- Single miss: after reset, gfx1_cs=1, gfx1_addr=18'h00123 -> sdram_req=1 with sdram_addr=22'h080123. ack on cycle 3, rdy with din=16'hBEEF on cycle 6 -> gfx1_ok=1 and gfx1_data=16'hBEEF on cycle 7.
- Hit: the same address held afterwards -> gfx1_ok stays 1 and no new sdram_req.
- Contention: both clients miss in the same cycle (gfx1 addr 18'h10, gfx2 addr 18'h20) -> gfx1 is served first at 22'h080010, then gfx2 at 22'h100020. On the next simultaneous miss gfx1 wins again, because last=gfx2.
- Mid-fetch address change: gfx2 issues addr 18'h40 and switches to 18'h41 before rdy -> after rdy gfx2_ok=0, then a second request to 22'h100041 is issued.
- Reset mid-operation: assert rst during WAIT_DATA -> sdram_req=0 and both ok=0 immediately. Fetches restart after rst deasserts, and a late rdy pulse arriving after reset is ignored.
- cs low: gfx1_cs=0 with any addr -> no request and gfx1_ok=0. Raising cs on a cached address gives ok=1 in the same cycle.

Source files
------------

// File: rtl/jtcontra_gfx_romslot_pkg.sv
// Shared types and defaults for the gfx ROM slot: FSM encoding and SDRAM bases.
package jtcontra_gfx_romslot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_t;

  localparam logic [21:0] GFX1_OFFSET_DEF = 22'h08_0000;
  localparam logic [21:0] GFX2_OFFSET_DEF = 22'h10_0000;

endpackage

// File: rtl/jtcontra_romslot_cache.sv
// Single-entry word cache for one gfx client: tag/data/valid plus hit and ok.
module jtcontra_romslot_cache (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [17:0] addr_i,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [17:0] wtag_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] data_o,
  output logic        ok_o,
  output logic        miss_o
);

  logic [17:0] tag_q, tag_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        hit;

  // Load the entry when the FSM retires a fetch for this client.
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (we_i) begin
      tag_d   = wtag_i;
      data_d  = wdata_i;
      valid_d = 1'b1;
    end
  end

  // Entry storage, cleared on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit    = valid_q & (tag_q == addr_i);
  assign ok_o   = cs_i & hit;
  assign miss_o = cs_i & ~hit;
  assign data_o = data_q;

endmodule

// File: rtl/jtcontra_gfx_romslot.sv
// Arbitrates gfx1/gfx2 ROM fetches onto one SDRAM request port, one cached word per client.
module jtcontra_gfx_romslot
  import jtcontra_gfx_romslot_pkg::*;
#(
  parameter logic [21:0] GFX1_OFFSET = GFX1_OFFSET_DEF,
  parameter logic [21:0] GFX2_OFFSET = GFX2_OFFSET_DEF
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [17:0] gfx1_addr,
  input  logic        gfx1_cs,
  output logic [15:0] gfx1_data,
  output logic        gfx1_ok,
  input  logic [17:0] gfx2_addr,
  input  logic        gfx2_cs,
  output logic [15:0] gfx2_data,
  output logic        gfx2_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [15:0] sdram_din
);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;       // 0: gfx1, 1: gfx2
  logic        last_q, last_d;     // client served most recently
  logic [17:0] req_tag_q, req_tag_d;
  logic [21:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        miss1, miss2, we1, we2;

  jtcontra_romslot_cache u_cache1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (gfx1_addr),
    .cs_i    (gfx1_cs),
    .we_i    (we1),
    .wtag_i  (req_tag_q),
    .wdata_i (sdram_din),
    .data_o  (gfx1_data),
    .ok_o    (gfx1_ok),
    .miss_o  (miss1)
  );

  jtcontra_romslot_cache u_cache2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (gfx2_addr),
    .cs_i    (gfx2_cs),
    .we_i    (we2),
    .wtag_i  (req_tag_q),
    .wdata_i (sdram_din),
    .data_o  (gfx2_data),
    .ok_o    (gfx2_ok),
    .miss_o  (miss2)
  );

  // Next-state: pick a missing client round-robin, hold the request until ack, retire on rdy.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    req_tag_d = req_tag_q;
    addr_d    = addr_q;
    req_d     = req_q;
    we1       = 1'b0;
    we2       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss1 | miss2) begin
          sel_d     = (miss1 & miss2) ? ~last_q : miss2;
          req_tag_d = sel_d ? gfx2_addr : gfx1_addr;
          addr_d    = (sel_d ? GFX2_OFFSET : GFX1_OFFSET) + {4'd0, req_tag_d};
          req_d     = 1'b1;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (sdram_rdy) begin
          we1     = ~sel_q;
          we2     = sel_q;
          last_d  = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      req_tag_q <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      req_tag_q <= req_tag_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
    end
  end

  assign sdram_addr = addr_q;
  assign sdram_req  = req_q;

endmodule
